// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: syncs divider clocks and switches, debounces pause,
// runs RUN/PAUSED/ADJUST and issues registered single-cycle increment and blink controls.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       btn_pause,
    input  logic       adj,
    input  logic       sel,
    output logic       tick_sec,
    output logic       inc_min,
    output logic       inc_sec,
    output logic       blink_min,
    output logic       blink_sec,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        PAUSED = 2'b01,
        ADJUST = 2'b10
    } state_t;

    // bit order in the sync chains: {clk_1hz, clk_2hz, btn_pause, adj, sel}
    logic [4:0]      sync1;
    logic [4:0]      sync2;
    logic [1:0]      prev;
    logic            rise_1hz;
    logic            rise_2hz;
    logic            lvl_2hz;
    logic            btn_s;
    logic            adj_s;
    logic            sel_s;
    logic            db_stable;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic            resume_paused;
    state_t          state;

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {clk_1hz, clk_2hz, btn_pause, adj, sel};
            sync2 <= sync1;
            prev  <= sync2[4:3];
        end
    end

    assign rise_1hz = sync2[4] & ~prev[1];
    assign rise_2hz = sync2[3] & ~prev[0];
    assign lvl_2hz  = sync2[3];
    assign btn_s    = sync2[2];
    assign adj_s    = sync2[1];
    assign sel_s    = sync2[0];

    // Only a settled 0->1 change counts as a press; releases are silent.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            db_stable <= 1'b0;
            db_cnt    <= '0;
            press     <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s == db_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_stable <= ~db_stable;
                db_cnt    <= '0;
                press     <= ~db_stable;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state         <= PAUSED;
            resume_paused <= 1'b0;
            tick_sec      <= 1'b0;
            inc_min       <= 1'b0;
            inc_sec       <= 1'b0;
            blink_min     <= 1'b0;
            blink_sec     <= 1'b0;
        end else begin
            tick_sec  <= 1'b0;
            inc_min   <= 1'b0;
            inc_sec   <= 1'b0;
            blink_min <= 1'b0;
            blink_sec <= 1'b0;
            case (state)
                RUN: begin
                    tick_sec <= rise_1hz;
                    if (adj_s) begin
                        state         <= ADJUST;
                        resume_paused <= 1'b0;
                    end else if (press) begin
                        state <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (adj_s) begin
                        state         <= ADJUST;
                        resume_paused <= 1'b1;
                    end else if (press) begin
                        state <= RUN;
                    end
                end
                ADJUST: begin
                    // Leaving ADJUST suppresses any 2 Hz increment in that same cycle.
                    if (!adj_s) begin
                        state <= resume_paused ? PAUSED : RUN;
                    end else begin
                        if (press) resume_paused <= ~resume_paused;
                        if (sel_s) begin
                            inc_sec   <= rise_2hz;
                            blink_sec <= lvl_2hz;
                        end else begin
                            inc_min   <= rise_2hz;
                            blink_min <= lvl_2hz;
                        end
                    end
                end
                default: state <= PAUSED;
            endcase
        end
    end

    assign mode = state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl: a cycle reference model queues expected outputs,
// a monitor pops and compares them after every clock edge.
module tb_stopwatch_ctrl;
    localparam int N    = 4;
    localparam int NCYC = 4000;

    logic       clk_fast  = 1'b0;
    logic       rst       = 1'b1;
    logic       clk_1hz   = 1'b0;
    logic       clk_2hz   = 1'b0;
    logic       btn_pause = 1'b0;
    logic       adj       = 1'b0;
    logic       sel       = 1'b0;
    logic       tick_sec;
    logic       inc_min;
    logic       inc_sec;
    logic       blink_min;
    logic       blink_sec;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;
    int n_tick   = 0;
    int n_imin   = 0;
    int n_isec   = 0;
    int cyc_mon  = 0;

    logic [6:0] exp_q[$];

    always #5 clk_fast = ~clk_fast;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(N), .DB_W(4)) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .clk_1hz  (clk_1hz),
        .clk_2hz  (clk_2hz),
        .btn_pause(btn_pause),
        .adj      (adj),
        .sel      (sel),
        .tick_sec (tick_sec),
        .inc_min  (inc_min),
        .inc_sec  (inc_sec),
        .blink_min(blink_min),
        .blink_sec(blink_sec),
        .mode     (mode)
    );

    // Reference model: raw input history (bit n = value sampled n edges ago),
    // mode as an integer 0=RUN 1=PAUSED 2=ADJUST.
    bit [3:0] h1, h2, hb, ha, hs;
    int       m_mode   = 1;
    bit       m_resume = 1'b0;
    bit       m_press  = 1'b0;
    bit       m_stable = 1'b0;
    int       m_disagree = 0;

    task automatic model_step(input bit r, input bit c1, input bit c2,
                              input bit b, input bit a, input bit s);
        bit t, im, is, bm, bsk, newp, rise1, rise2;
        int nmode;
        t = 0; im = 0; is = 0; bm = 0; bsk = 0; newp = 0;
        if (r) begin
            h1 = '0; h2 = '0; hb = '0; ha = '0; hs = '0;
            m_mode = 1; m_resume = 0; m_press = 0; m_stable = 0; m_disagree = 0;
        end else begin
            h1 = {h1[2:0], c1};
            h2 = {h2[2:0], c2};
            hb = {hb[2:0], b};
            ha = {ha[2:0], a};
            hs = {hs[2:0], s};
            // the logic sees each input two edges late; a rise is new-high vs one edge older
            rise1 = h1[2] && !h1[3];
            rise2 = h2[2] && !h2[3];
            // N consecutive disagreeing samples flip the accepted button level
            if (hb[2] == m_stable) begin
                m_disagree = 0;
            end else begin
                m_disagree++;
                if (m_disagree == N) begin
                    m_stable   = !m_stable;
                    m_disagree = 0;
                    newp       = m_stable;
                end
            end
            nmode = m_mode;
            if (m_mode == 0) begin
                t = rise1;
                if (ha[2]) begin nmode = 2; m_resume = 0; end
                else if (m_press) nmode = 1;
            end else if (m_mode == 1) begin
                if (ha[2]) begin nmode = 2; m_resume = 1; end
                else if (m_press) nmode = 0;
            end else begin
                if (!ha[2]) begin
                    nmode = m_resume ? 1 : 0;
                end else begin
                    if (m_press) m_resume = !m_resume;
                    if (hs[2]) begin is = rise2; bsk = h2[2]; end
                    else begin im = rise2; bm = h2[2]; end
                end
            end
            m_mode  = nmode;
            m_press = newp;
        end
        exp_q.push_back({2'(m_mode), t, im, is, bm, bsk});
    endtask

    // Monitor: compare every registered output set one delta after the edge.
    initial begin
        logic [6:0] e, got;
        forever begin
            @(posedge clk_fast);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {mode, tick_sec, inc_min, inc_sec, blink_min, blink_sec};
                cyc_mon++;
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: got mode=%b tick=%b imin=%b isec=%b bmin=%b bsec=%b required mode=%b tick=%b imin=%b isec=%b bmin=%b bsec=%b",
                             cyc_mon, got[6:5], got[4], got[3], got[2], got[1], got[0],
                             e[6:5], e[4], e[3], e[2], e[1], e[0]);
                end
                checks++;
                if ($countones({tick_sec, inc_min, inc_sec}) > 1) begin
                    failures++;
                    $display("FAIL pulse_exclusive cycle %0d: got tick/imin/isec=%b%b%b required at most one high",
                             cyc_mon, tick_sec, inc_min, inc_sec);
                end
                n_tick += int'(tick_sec === 1'b1);
                n_imin += int'(inc_min === 1'b1);
                n_isec += int'(inc_sec === 1'b1);
            end
        end
    end

    // Driver: random slow square waves, phased button activity, rare switch flips and resets.
    initial begin
        int c1_left, c2_left, ph_left, ph_kind, rst_hold;
        c1_left = 6; c2_left = 3; ph_left = 0; ph_kind = 0; rst_hold = 2;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk_fast);
            if (rst_hold > 0) begin
                rst = 1'b1;
                rst_hold--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 499) == 0) rst_hold = $urandom_range(1, 2);
            end
            if (--c1_left <= 0) begin
                clk_1hz = ~clk_1hz;
                c1_left = $urandom_range(4, 14);
            end
            if (--c2_left <= 0) begin
                clk_2hz = ~clk_2hz;
                c2_left = $urandom_range(2, 7);
            end
            if (ph_left <= 0) begin
                ph_kind = $urandom_range(0, 3);
                ph_left = $urandom_range(15, 60);
            end
            ph_left--;
            case (ph_kind)
                0: btn_pause = 1'b0;
                1: btn_pause = 1'b1;
                2: btn_pause = 1'($urandom_range(0, 1));
                default: if (cyc % 2 == 0) btn_pause = ~btn_pause;
            endcase
            if ($urandom_range(0, 149) == 0) adj = ~adj;
            if ($urandom_range(0, 49) == 0) sel = ~sel;
            model_step(rst, clk_1hz, clk_2hz, btn_pause, adj, sel);
        end
        repeat (3) @(negedge clk_fast);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        checks++;
        if (n_tick == 0) begin
            failures++;
            $display("FAIL tick_seen: got %0d tick_sec pulses required > 0", n_tick);
        end
        checks++;
        if (n_imin == 0) begin
            failures++;
            $display("FAIL inc_min_seen: got %0d inc_min pulses required > 0", n_imin);
        end
        checks++;
        if (n_isec == 0) begin
            failures++;
            $display("FAIL inc_sec_seen: got %0d inc_sec pulses required > 0", n_isec);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
